// File: rtl/arm_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : arm_pipe_hazard_ctrl
//  Brief    : IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers for the ARM
//             datapath. Provides per-stage valid bits, a load-use interlock,
//             taken-branch flush, a global external stall and EX operand
//             forwarding. Control words are carried opaquely.
//  Revision : 1.0 - initial release
// ============================================================================
module arm_pipe_hazard_ctrl #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int CW        = 32,
  parameter int RW        = 4,
  parameter int NOFWD_REG = 15
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            ext_stall,
  output logic            pc_en,
  // fetch side
  input  logic            if_valid,
  input  logic [DW-1:0]   if_instr,
  input  logic [AW-1:0]   if_pc,
  // decode side
  output logic            id_valid,
  output logic [DW-1:0]   id_instr,
  input  logic [CW-1:0]   id_ctrl,
  input  logic [3*RW-1:0] id_regs,
  input  logic [3:0]      id_flags,
  input  logic [DW-1:0]   id_opa,
  input  logic [DW-1:0]   id_opb,
  // execute side
  output logic            ex_valid,
  output logic [CW-1:0]   ex_ctrl,
  output logic [AW-1:0]   ex_pc,
  output logic [DW-1:0]   ex_a,
  output logic [DW-1:0]   ex_b,
  input  logic [DW-1:0]   ex_result,
  input  logic            ex_branch_taken,
  // memory side
  output logic            mem_valid,
  output logic [CW-1:0]   mem_ctrl,
  output logic [DW-1:0]   mem_alu,
  output logic [DW-1:0]   mem_data,
  input  logic [DW-1:0]   mem_rdata,
  // writeback side
  output logic            wb_we,
  output logic [RW-1:0]   wb_rd,
  output logic [DW-1:0]   wb_value,
  output logic [CW-1:0]   wb_ctrl,
  output logic [3:0]      fwd_sel
);

  localparam logic [1:0]    c_sel_rf   = 2'b00;
  localparam logic [1:0]    c_sel_mem  = 2'b01;
  localparam logic [1:0]    c_sel_wb   = 2'b10;
  localparam logic [RW-1:0] c_nofwd    = RW'(NOFWD_REG);

  // Flag bit positions within {is_load, wr_rd, use_rm, use_rn}
  localparam int            c_f_use_rn  = 0;
  localparam int            c_f_use_rm  = 1;
  localparam int            c_f_wr_rd   = 2;
  localparam int            c_f_is_load = 3;

  // ---------------------------------------------------------------- IF/ID
  logic            id_valid_q, id_valid_d;
  logic [DW-1:0]   id_instr_q, id_instr_d;
  logic [AW-1:0]   id_pc_q,    id_pc_d;

  // ---------------------------------------------------------------- ID/EX
  logic            ex_valid_q, ex_valid_d;
  logic [CW-1:0]   ex_ctrl_q,  ex_ctrl_d;
  logic [AW-1:0]   ex_pc_q,    ex_pc_d;
  logic [3*RW-1:0] ex_regs_q,  ex_regs_d;
  logic [3:0]      ex_flags_q, ex_flags_d;
  logic [DW-1:0]   ex_opa_q,   ex_opa_d;
  logic [DW-1:0]   ex_opb_q,   ex_opb_d;

  // --------------------------------------------------------------- EX/MEM
  logic            mem_valid_q,   mem_valid_d;
  logic [CW-1:0]   mem_ctrl_q,    mem_ctrl_d;
  logic [DW-1:0]   mem_alu_q,     mem_alu_d;
  logic [DW-1:0]   mem_data_q,    mem_data_d;
  logic [RW-1:0]   mem_rd_q,      mem_rd_d;
  logic            mem_is_load_q, mem_is_load_d;
  logic            mem_wr_rd_q,   mem_wr_rd_d;

  // --------------------------------------------------------------- MEM/WB
  logic            wb_we_q,    wb_we_d;
  logic [RW-1:0]   wb_rd_q,    wb_rd_d;
  logic [DW-1:0]   wb_value_q, wb_value_d;
  logic [CW-1:0]   wb_ctrl_q,  wb_ctrl_d;

  // ------------------------------------------------------- decoded fields
  logic [RW-1:0]   w_id_rd, w_id_rm, w_id_rn;
  logic [RW-1:0]   w_ex_rd, w_ex_rm, w_ex_rn;
  logic            w_ex_use_rn, w_ex_use_rm, w_ex_wr_rd, w_ex_is_load;
  logic            w_flush;
  logic            w_load_use;
  logic            w_hold_id;
  logic [1:0]      w_a_sel, w_b_sel;
  logic [DW-1:0]   w_ex_a, w_ex_b;

  assign w_id_rn = id_regs[RW-1:0];
  assign w_id_rm = id_regs[2*RW-1:RW];
  assign w_id_rd = id_regs[3*RW-1:2*RW];

  assign w_ex_rn = ex_regs_q[RW-1:0];
  assign w_ex_rm = ex_regs_q[2*RW-1:RW];
  assign w_ex_rd = ex_regs_q[3*RW-1:2*RW];

  assign w_ex_use_rn  = ex_flags_q[c_f_use_rn];
  assign w_ex_use_rm  = ex_flags_q[c_f_use_rm];
  assign w_ex_wr_rd   = ex_flags_q[c_f_wr_rd];
  assign w_ex_is_load = ex_flags_q[c_f_is_load];

  // A taken branch resolved by a valid EX instruction redirects fetch.
  assign w_flush = ex_valid_q && ex_branch_taken;

  // A valid load in EX whose destination is read by the valid ID instruction.
  assign w_load_use = id_valid_q && ex_valid_q && w_ex_is_load && w_ex_wr_rd &&
                      ((id_flags[c_f_use_rn] && (w_id_rn == w_ex_rd)) ||
                       (id_flags[c_f_use_rm] && (w_id_rm == w_ex_rd)));

  // Flush wins over the interlock: the dependent instruction is discarded.
  assign w_hold_id = w_load_use && !w_flush;

  // PC advances unless frozen by memory or held by the interlock.
  assign pc_en = Reset || (!ext_stall && !w_hold_id);

  // Pick the freshest producer of each EX operand; EX/MEM is newer than MEM/WB.
  always_comb begin
    w_a_sel = c_sel_rf;
    w_b_sel = c_sel_rf;
    if (w_ex_use_rn && (w_ex_rn != c_nofwd)) begin
      if (mem_valid_q && mem_wr_rd_q && !mem_is_load_q && (mem_rd_q == w_ex_rn))
        w_a_sel = c_sel_mem;
      else if (wb_we_q && (wb_rd_q == w_ex_rn))
        w_a_sel = c_sel_wb;
    end
    if (w_ex_use_rm && (w_ex_rm != c_nofwd)) begin
      if (mem_valid_q && mem_wr_rd_q && !mem_is_load_q && (mem_rd_q == w_ex_rm))
        w_b_sel = c_sel_mem;
      else if (wb_we_q && (wb_rd_q == w_ex_rm))
        w_b_sel = c_sel_wb;
    end
  end

  // Operand muxes driven by the forwarding selects.
  always_comb begin
    unique case (w_a_sel)
      c_sel_mem: w_ex_a = mem_alu_q;
      c_sel_wb:  w_ex_a = wb_value_q;
      default:   w_ex_a = ex_opa_q;
    endcase
    unique case (w_b_sel)
      c_sel_mem: w_ex_b = mem_alu_q;
      c_sel_wb:  w_ex_b = wb_value_q;
      default:   w_ex_b = ex_opb_q;
    endcase
  end

  // IF/ID next state: flushed on a taken branch, held by the interlock.
  always_comb begin
    id_valid_d = if_valid;
    id_instr_d = if_instr;
    id_pc_d    = if_pc;
    if (w_flush) begin
      id_valid_d = 1'b0;
      id_instr_d = '0;
      id_pc_d    = '0;
    end else if (w_load_use) begin
      id_valid_d = id_valid_q;
      id_instr_d = id_instr_q;
      id_pc_d    = id_pc_q;
    end
  end

  // ID/EX next state: a bubble is inserted on flush or interlock.
  always_comb begin
    ex_valid_d = id_valid_q;
    ex_ctrl_d  = id_ctrl;
    ex_pc_d    = id_pc_q;
    ex_regs_d  = id_regs;
    ex_flags_d = id_valid_q ? id_flags : 4'b0000;
    ex_opa_d   = id_opa;
    ex_opb_d   = id_opb;
    if (w_flush || w_load_use) begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = '0;
      ex_pc_d    = '0;
      ex_regs_d  = '0;
      ex_flags_d = 4'b0000;
      ex_opa_d   = '0;
      ex_opb_d   = '0;
    end
  end

  // EX/MEM next state: always advances (including the resolving branch).
  always_comb begin
    mem_valid_d   = ex_valid_q;
    mem_ctrl_d    = ex_ctrl_q;
    mem_alu_d     = ex_result;
    mem_data_d    = w_ex_b;
    mem_rd_d      = w_ex_rd;
    mem_is_load_d = w_ex_is_load;
    mem_wr_rd_d   = w_ex_wr_rd;
  end

  // MEM/WB next state: select loaded data or ALU result for writeback.
  always_comb begin
    wb_we_d    = mem_valid_q && mem_wr_rd_q;
    wb_rd_d    = mem_rd_q;
    wb_value_d = mem_is_load_q ? mem_rdata : mem_alu_q;
    wb_ctrl_d  = mem_ctrl_q;
  end

  // Pipeline registers: cleared on reset, frozen as a whole by ext_stall.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      id_valid_q    <= 1'b0;
      id_instr_q    <= '0;
      id_pc_q       <= '0;
      ex_valid_q    <= 1'b0;
      ex_ctrl_q     <= '0;
      ex_pc_q       <= '0;
      ex_regs_q     <= '0;
      ex_flags_q    <= 4'b0000;
      ex_opa_q      <= '0;
      ex_opb_q      <= '0;
      mem_valid_q   <= 1'b0;
      mem_ctrl_q    <= '0;
      mem_alu_q     <= '0;
      mem_data_q    <= '0;
      mem_rd_q      <= '0;
      mem_is_load_q <= 1'b0;
      mem_wr_rd_q   <= 1'b0;
      wb_we_q       <= 1'b0;
      wb_rd_q       <= '0;
      wb_value_q    <= '0;
      wb_ctrl_q     <= '0;
    end else if (!ext_stall) begin
      id_valid_q    <= id_valid_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      ex_valid_q    <= ex_valid_d;
      ex_ctrl_q     <= ex_ctrl_d;
      ex_pc_q       <= ex_pc_d;
      ex_regs_q     <= ex_regs_d;
      ex_flags_q    <= ex_flags_d;
      ex_opa_q      <= ex_opa_d;
      ex_opb_q      <= ex_opb_d;
      mem_valid_q   <= mem_valid_d;
      mem_ctrl_q    <= mem_ctrl_d;
      mem_alu_q     <= mem_alu_d;
      mem_data_q    <= mem_data_d;
      mem_rd_q      <= mem_rd_d;
      mem_is_load_q <= mem_is_load_d;
      mem_wr_rd_q   <= mem_wr_rd_d;
      wb_we_q       <= wb_we_d;
      wb_rd_q       <= wb_rd_d;
      wb_value_q    <= wb_value_d;
      wb_ctrl_q     <= wb_ctrl_d;
    end
  end

  assign id_valid  = id_valid_q;
  assign id_instr  = id_instr_q;
  assign ex_valid  = ex_valid_q;
  assign ex_ctrl   = ex_ctrl_q;
  assign ex_pc     = ex_pc_q;
  assign ex_a      = w_ex_a;
  assign ex_b      = w_ex_b;
  assign mem_valid = mem_valid_q;
  assign mem_ctrl  = mem_ctrl_q;
  assign mem_alu   = mem_alu_q;
  assign mem_data  = mem_data_q;
  assign wb_we     = wb_we_q;
  assign wb_rd     = wb_rd_q;
  assign wb_value  = wb_value_q;
  assign wb_ctrl   = wb_ctrl_q;
  assign fwd_sel   = {w_b_sel, w_a_sel};

endmodule
`default_nettype wire

// File: tb/tb_arm_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arm_pipe_hazard_ctrl
//  Brief    : Directed self-checking bench for arm_pipe_hazard_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_arm_pipe_hazard_ctrl;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int CW = 32;
  localparam int RW = 4;

  logic            Clk = 1'b0;
  logic            Reset;
  logic            ext_stall;
  logic            pc_en;
  logic            if_valid;
  logic [DW-1:0]   if_instr;
  logic [AW-1:0]   if_pc;
  logic            id_valid;
  logic [DW-1:0]   id_instr;
  logic [CW-1:0]   id_ctrl;
  logic [3*RW-1:0] id_regs;
  logic [3:0]      id_flags;
  logic [DW-1:0]   id_opa;
  logic [DW-1:0]   id_opb;
  logic            ex_valid;
  logic [CW-1:0]   ex_ctrl;
  logic [AW-1:0]   ex_pc;
  logic [DW-1:0]   ex_a;
  logic [DW-1:0]   ex_b;
  logic [DW-1:0]   ex_result;
  logic            ex_branch_taken;
  logic            mem_valid;
  logic [CW-1:0]   mem_ctrl;
  logic [DW-1:0]   mem_alu;
  logic [DW-1:0]   mem_data;
  logic [DW-1:0]   mem_rdata;
  logic            wb_we;
  logic [RW-1:0]   wb_rd;
  logic [DW-1:0]   wb_value;
  logic [CW-1:0]   wb_ctrl;
  logic [3:0]      fwd_sel;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  arm_pipe_hazard_ctrl #(
    .DW(DW), .AW(AW), .CW(CW), .RW(RW), .NOFWD_REG(15)
  ) u_dut (
    .Clk(Clk), .Reset(Reset), .ext_stall(ext_stall), .pc_en(pc_en),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_valid(id_valid), .id_instr(id_instr), .id_ctrl(id_ctrl),
    .id_regs(id_regs), .id_flags(id_flags), .id_opa(id_opa), .id_opb(id_opb),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc), .ex_a(ex_a),
    .ex_b(ex_b), .ex_result(ex_result), .ex_branch_taken(ex_branch_taken),
    .mem_valid(mem_valid), .mem_ctrl(mem_ctrl), .mem_alu(mem_alu),
    .mem_data(mem_data), .mem_rdata(mem_rdata),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_value(wb_value), .wb_ctrl(wb_ctrl),
    .fwd_sel(fwd_sel)
  );

  // Toy decoder: instr = {16'h0, flags, rd, rm, rn}; register file holds 0x100+r / 0x200+r.
  always_comb begin
    id_regs  = {id_instr[11:8], id_instr[7:4], id_instr[3:0]};
    id_flags = id_instr[15:12];
    id_ctrl  = id_instr ^ 32'h5A5A_0000;
    id_opa   = 32'h100 + {28'd0, id_instr[3:0]};
    id_opb   = 32'h200 + {28'd0, id_instr[7:4]};
  end

  function automatic logic [31:0] enc(input logic [3:0] rd, input logic [3:0] rm,
                                      input logic [3:0] rn, input logic [3:0] flg);
    return {16'h0000, flg, rd, rm, rn};
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset           = 1'b1;
    ext_stall       = 1'b0;
    if_valid        = 1'b0;
    ex_branch_taken = 1'b0;
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] i1, i2, ld, ad, tgt, wr, rd;

    Reset           = 1'b1;
    ext_stall       = 1'b0;
    if_valid        = 1'b0;
    if_instr        = '0;
    if_pc           = '0;
    ex_result       = '0;
    ex_branch_taken = 1'b0;
    mem_rdata       = '0;
    #1;
    chk("pc_en_in_reset", 64'(pc_en), 64'd1);
    tick();
    Reset = 1'b0;
    #1;
    chk("rst_id_valid", 64'(id_valid), 64'd0);
    chk("rst_ex_valid", 64'(ex_valid), 64'd0);
    chk("rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_wb_we", 64'(wb_we), 64'd0);
    chk("rst_fwd_sel", 64'(fwd_sel), 64'd0);

    // ---------------- EX/MEM forwarding, then ext_stall for 3 cycles
    do_reset();
    i1 = enc(4'd1, 4'd3, 4'd2, 4'h7);
    i2 = enc(4'd2, 4'd3, 4'd1, 4'h7);
    if_valid = 1'b1; if_instr = i1; if_pc = 32'h1004;
    tick();
    if_instr = i2; if_pc = 32'h1008;
    tick();
    chk("fw_ex_ctrl", 64'(ex_ctrl), 64'(i1 ^ 32'h5A5A_0000));
    if_valid = 1'b0; ex_result = 32'h10;
    tick();
    ex_result = 32'h20;
    #1;
    chk("fw_sel", 64'(fwd_sel), 64'b0001);
    chk("fw_ex_a", 64'(ex_a), 64'h10);
    chk("fw_ex_b", 64'(ex_b), 64'h203);
    chk("fw_ex_pc", 64'(ex_pc), 64'h1008);
    chk("fw_mem_alu", 64'(mem_alu), 64'h10);
    ext_stall = 1'b1;
    #1;
    chk("st_pc_en", 64'(pc_en), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("st_fwd_sel", 64'(fwd_sel), 64'b0001);
      chk("st_ex_a", 64'(ex_a), 64'h10);
      chk("st_mem_alu", 64'(mem_alu), 64'h10);
      chk("st_ex_valid", 64'(ex_valid), 64'd1);
      chk("st_wb_we", 64'(wb_we), 64'd0);
      chk("st_pc_en_hold", 64'(pc_en), 64'd0);
    end
    ext_stall = 1'b0;
    tick();
    chk("rs_wb_we", 64'(wb_we), 64'd1);
    chk("rs_wb_rd", 64'(wb_rd), 64'd1);
    chk("rs_wb_value", 64'(wb_value), 64'h10);
    chk("rs_mem_alu", 64'(mem_alu), 64'h20);
    chk("rs_mem_data", 64'(mem_data), 64'h203);
    chk("rs_ex_valid", 64'(ex_valid), 64'd0);
    tick();
    chk("rs_wb_rd2", 64'(wb_rd), 64'd2);
    chk("rs_wb_value2", 64'(wb_value), 64'h20);

    // ---------------- load-use interlock
    do_reset();
    ld = enc(4'd1, 4'd0, 4'd4, 4'hD);
    ad = enc(4'd2, 4'd1, 4'd1, 4'h7);
    if_valid = 1'b1; if_instr = ld;
    tick();
    if_instr = ad;
    tick();
    if_valid = 1'b0; ex_result = 32'h40;
    #1;
    chk("lu_pc_en0", 64'(pc_en), 64'd0);
    chk("lu_ex_valid_ld", 64'(ex_valid), 64'd1);
    tick();
    chk("lu_bubble", 64'(ex_valid), 64'd0);
    chk("lu_id_hold", 64'(id_instr), 64'(ad));
    chk("lu_id_valid", 64'(id_valid), 64'd1);
    chk("lu_mem_alu", 64'(mem_alu), 64'h40);
    chk("lu_pc_en1", 64'(pc_en), 64'd1);
    mem_rdata = 32'hCAFE;
    tick();
    chk("lu_ex_valid", 64'(ex_valid), 64'd1);
    chk("lu_fwd_sel", 64'(fwd_sel), 64'b1010);
    chk("lu_ex_a", 64'(ex_a), 64'hCAFE);
    chk("lu_ex_b", 64'(ex_b), 64'hCAFE);
    chk("lu_wb_value", 64'(wb_value), 64'hCAFE);
    chk("lu_mem_valid", 64'(mem_valid), 64'd0);

    // ---------------- taken branch overrides load-use
    do_reset();
    if_valid = 1'b1; if_instr = ld;
    tick();
    if_instr = ad;
    tick();
    if_instr = enc(4'd9, 4'd0, 4'd0, 4'h4);
    ex_branch_taken = 1'b1; ex_result = 32'h2000;
    #1;
    chk("br_pc_en", 64'(pc_en), 64'd1);
    tick();
    ex_branch_taken = 1'b0;
    tgt = enc(4'd3, 4'd0, 4'd0, 4'h4);
    if_instr = tgt;
    #1;
    chk("br_id_valid", 64'(id_valid), 64'd0);
    chk("br_ex_valid", 64'(ex_valid), 64'd0);
    chk("br_ex_ctrl", 64'(ex_ctrl), 64'd0);
    chk("br_mem_valid", 64'(mem_valid), 64'd1);
    chk("br_mem_alu", 64'(mem_alu), 64'h2000);
    chk("br_pc_en_after", 64'(pc_en), 64'd1);
    tick();
    if_valid = 1'b0;
    chk("br_target", 64'(id_instr), 64'(tgt));
    chk("br_target_valid", 64'(id_valid), 64'd1);

    // ---------------- r15 is never forwarded
    do_reset();
    wr = enc(4'd15, 4'd3, 4'd2, 4'h7);
    rd = enc(4'd5, 4'd15, 4'd15, 4'h7);
    if_valid = 1'b1; if_instr = wr;
    tick();
    if_instr = rd;
    tick();
    if_valid = 1'b0;
    tick();
    chk("pc_fwd_sel", 64'(fwd_sel), 64'd0);
    chk("pc_ex_a", 64'(ex_a), 64'h10F);
    chk("pc_ex_b", 64'(ex_b), 64'h20F);
    tick();
    chk("pc_wb_rd", 64'(wb_rd), 64'd15);

    // ---------------- reset mid-stream with every stage valid
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      if_valid = 1'b1;
      if_instr = enc(4'(k + 4), 4'(k), 4'(k), 4'h4);
      tick();
    end
    chk("ms_id_valid", 64'(id_valid), 64'd1);
    chk("ms_ex_valid", 64'(ex_valid), 64'd1);
    chk("ms_mem_valid", 64'(mem_valid), 64'd1);
    chk("ms_wb_we", 64'(wb_we), 64'd1);
    chk("ms_wb_rd", 64'(wb_rd), 64'd5);
    Reset = 1'b1; ext_stall = 1'b1;
    #1;
    chk("ms_pc_en_rst", 64'(pc_en), 64'd1);
    tick();
    Reset = 1'b0; ext_stall = 1'b0; if_valid = 1'b0;
    #1;
    chk("mr_id_valid", 64'(id_valid), 64'd0);
    chk("mr_ex_valid", 64'(ex_valid), 64'd0);
    chk("mr_mem_valid", 64'(mem_valid), 64'd0);
    chk("mr_wb_we", 64'(wb_we), 64'd0);
    chk("mr_fwd_sel", 64'(fwd_sel), 64'd0);
    chk("mr_pc_en", 64'(pc_en), 64'd1);
    chk("mr_wb_value", 64'(wb_value), 64'd0);
    chk("mr_ex_ctrl", 64'(ex_ctrl), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arm_pipe_hazard_ctrl.md
# arm_pipe_hazard_ctrl
Parametrised pipeline register chain (IF/ID, ID/EX, EX/MEM, MEM/WB) for the ARM datapath. It adds per-stage valid bits, load-use interlock, taken-branch flush, a global external stall and EX-stage operand forwarding. Fetch, decode, ALU/shifter and data memory connect around it. Control words pass through opaquely.
## Interface
- DW, 32, data/instruction/operand width
- AW, 32, PC width
- CW, 32, control-word width
- RW, 4, register-index width
- NOFWD_REG, 15, register index never forwarded (PC)
- Clk  in  1  clock
- Reset  in  1  synchronous, active-high
- ext_stall  in  1  freeze all stages (memory wait)
- pc_en  out  1  PC load enable
- if_valid  in  1  fetched instruction valid
- if_instr  in  DW  fetched instruction
- if_pc  in  AW  PC+4 of fetched instruction
- id_valid  out  1  IF/ID valid
- id_instr  out  DW  IF/ID instruction
- id_ctrl  in  CW  decoded control word
- id_regs  in  3*RW  {rd, rm, rn} from decoder
- id_flags  in  4  {is_load, wr_rd, use_rm, use_rn}
- id_opa, id_opb  in  DW  register-file read values
- ex_valid  out  1  ID/EX valid
- ex_ctrl  out  CW  ID/EX control word
- ex_pc  out  AW  ID/EX PC+4
- ex_a, ex_b  out  DW  forwarded operands (comb.)
- ex_result  in  DW  ALU/shifter result
- ex_branch_taken  in  1  branch resolved taken in EX
- mem_valid  out  1  EX/MEM valid
- mem_ctrl  out  CW  EX/MEM control word
- mem_alu  out  DW  EX/MEM result (address)
- mem_data  out  DW  EX/MEM store data (registered ex_b)
- mem_rdata  in  DW  data-memory read data
- wb_we  out  1  MEM/WB valid && wr_rd
- wb_rd  out  RW  writeback register
- wb_value  out  DW  is_load ? loaded data : ALU result
- wb_ctrl  out  CW  MEM/WB control word
- fwd_sel  out  4  {b_sel, a_sel}: 00 regfile, 01 EX/MEM, 10 MEM/WB
## Operation
- Priority per edge: Reset > ext_stall > branch flush > load-use stall > advance.
- ext_stall=1: every register holds, pc_en=0. A pending branch_taken stays asserted because ID/EX holds. It is acted on after the stall releases.
- Flush (ex_valid && ex_branch_taken): IF/ID and ID/EX load valid=0 and ctrl=0. EX/MEM captures the branch. pc_en=1. Any load-use condition is ignored in that cycle.
- Load-use stall: id_valid && ex_valid && ex.is_load && ex.wr_rd && ((use_rn && rn==ex.rd) || (use_rm && rm==ex.rd)). Effect: pc_en=0, IF/ID holds, ID/EX loads a bubble (valid=0, ctrl=0), EX/MEM and MEM/WB advance.
- Forwarding for operand A (B is symmetric with rm/use_rm):
  - EX/MEM source (01) when mem_valid && mem.wr_rd && !mem.is_load && mem.rd==ex.rn && ex.use_rn && ex.rn!=NOFWD_REG.
  - Otherwise MEM/WB source (10), supplying wb_value, when wb_we && wb_rd==ex.rn under the same use and NOFWD_REG conditions.
  - Otherwise 00, supplying id_op value registered in ID/EX.
  - EX/MEM takes priority over MEM/WB.
- Invalid stages never write, forward or raise stall/flush.
## Timing
- Reset: all valid bits, ctrl, data, pc and register fields clear to 0 on the clock edge. pc_en=1 during and after reset.
- Latency is one cycle per stage, so IF to WB takes 4 edges without stalls. A load-use stall adds exactly 1 bubble.
- pc_en, ex_a, ex_b and fwd_sel are combinational from registered state. All other outputs are registered.
## Test plan
- Reset mid-stream with all stages valid, Reset=1 for one edge -> all valid=0, wb_we=0, fwd_sel=0, pc_en=1.
- ADD r1 then ADD r2,r1,r3 back-to-back, ex_result=0x10 -> second op sees fwd_sel[1:0]=01 and ex_a=0x10.
- LDR r1 then ADD r2,r1,r1, with mem_rdata=0xCAFE -> one bubble (ex_valid=0 one cycle, pc_en=0 one cycle), then fwd_sel=1010 and ex_a=ex_b=0xCAFE.
- Taken branch in EX while a load-use condition is present in ID -> IF/ID and ID/EX invalid next cycle, pc_en=1, no bubble counted.
- ext_stall held 3 cycles during forwarding -> all outputs unchanged for 3 cycles, pc_en=0. Results resume identically after release.
- Writer rd=15 followed by a reader of r15 -> fwd_sel=00, and ex_a equals the registered id_opa.
